// File: rtl/whac_pkg.sv
// ----------------------------------------------------------------------------
//  whac_pkg : shared types and constants for the Whac-A-Mole game sequencer
//  Rev 1.0  : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package whac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_SEED     = 8'hA5;
  // Fibonacci feedback taps for x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam int         SCORE_W       = 7;
  localparam int         SCORE_MAX_DEF = 99;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/whac_mole_lfsr.sv
// ----------------------------------------------------------------------------
//  whac_mole_lfsr : free-running LFSR and no-repeat mole position picker
//  Rev 1.0        : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module whac_mole_lfsr
  import whac_pkg::*;
#(
  parameter int N_HOLES = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               load,
  output logic [N_HOLES-1:0] mole_next
);

  localparam int IDX_W = $clog2(N_HOLES);

  logic [7:0]       lfsr;
  logic [IDX_W-1:0] prev_idx;
  logic [IDX_W-1:0] raw_idx;
  logic [IDX_W-1:0] idx;

  // N_HOLES is a power of two, so the +1 wraps modulo N_HOLES for free
  always_comb begin
    raw_idx   = lfsr[IDX_W-1:0];
    idx       = (raw_idx == prev_idx) ? raw_idx + IDX_W'(1) : raw_idx;
    mole_next = N_HOLES'(1) << idx;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lfsr     <= LFSR_SEED;
      prev_idx <= '0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (load) prev_idx <= idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/whac_game_ctrl.sv
// ----------------------------------------------------------------------------
//  whac_game_ctrl : Whac-A-Mole sequencer (timer start, mole schedule, score)
//  Option         : define WHAC_MISS_PENALTY_EN to decrement score on misses
//  Rev 1.0        : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module whac_game_ctrl
  import whac_pkg::*;
#(
  parameter int N_HOLES     = 4,
  parameter int MOLE_PERIOD = 100_000_000,
  parameter int SCORE_MAX   = SCORE_MAX_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  input  logic [N_HOLES-1:0] hit,
  input  logic               finish_60s,
  output logic               start_60s,
  output logic [N_HOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               disp_sel
);

  localparam int                 CNT_W     = (MOLE_PERIOD > 1) ? $clog2(MOLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MOLE_PERIOD - 1);
  localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

  state_t               state;
  logic                 arm_phase;
  logic [CNT_W-1:0]     cnt;
  logic [N_HOLES-1:0]   mole_next;
  logic                 at_last;
  logic                 load_mole;
  logic [SCORE_W-1:0]   score_inc;
`ifdef WHAC_MISS_PENALTY_EN
  logic [SCORE_W-1:0]   score_dec;
  assign score_dec = (score == '0) ? '0 : score - SCORE_W'(1);
`endif

  assign at_last   = (cnt == CNT_LAST);
  assign score_inc = (score >= SCORE_CAP) ? SCORE_CAP : score + SCORE_W'(1);
  // A finishing game never loads a mole, so the no-repeat history stays put
  assign load_mole = ((state == ARM) && arm_phase) ||
                     ((state == RUN) && at_last && !finish_60s);

  whac_mole_lfsr #(
    .N_HOLES (N_HOLES)
  ) u_mole_lfsr (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (load_mole),
    .mole_next (mole_next)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      arm_phase <= 1'b0;
      cnt       <= '0;
      mole      <= '0;
      score     <= '0;
      start_60s <= 1'b0;
      game_over <= 1'b0;
      disp_sel  <= 1'b0;
    end else begin
      start_60s <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= ARM;
            arm_phase <= 1'b0;
            score     <= '0;
            start_60s <= 1'b1;
            game_over <= 1'b0;
            disp_sel  <= 1'b0;
          end
        end
        ARM: begin
          // Second cycle gives the timer time to drop a stale finish level
          if (!arm_phase) begin
            arm_phase <= 1'b1;
          end else begin
            state <= RUN;
            mole  <= mole_next;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= at_last ? '0 : cnt + CNT_W'(1);
          if (|(hit & mole)) begin
            score <= score_inc;
            mole  <= '0;
          end
`ifdef WHAC_MISS_PENALTY_EN
          else if (|hit) begin
            score <= score_dec;
          end
`endif
          if (finish_60s) begin
            state     <= OVER;
            mole      <= '0;
            game_over <= 1'b1;
            disp_sel  <= 1'b1;
          end else if (at_last) begin
            mole <= mole_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_whac_game_ctrl.sv
// ----------------------------------------------------------------------------
//  tb_whac_game_ctrl : random and directed checks of whac_game_ctrl against a
//  cycle-level game model (honours WHAC_MISS_PENALTY_EN)
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_whac_game_ctrl;

  localparam int NH   = 4;
  localparam int MP   = 10;
  localparam int SMAX = 99;
`ifdef WHAC_MISS_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          start = 1'b0;
  logic          finish_60s = 1'b0;
  logic [NH-1:0] hit = '0;
  logic          start_60s;
  logic [NH-1:0] mole;
  logic [6:0]    score;
  logic          game_over;
  logic          disp_sel;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  whac_game_ctrl #(
    .N_HOLES     (NH),
    .MOLE_PERIOD (MP),
    .SCORE_MAX   (SMAX)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .hit        (hit),
    .finish_60s (finish_60s),
    .start_60s  (start_60s),
    .mole       (mole),
    .score      (score),
    .game_over  (game_over),
    .disp_sel   (disp_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: game phase, mole hole index, score ----
  localparam int P_IDLE = 0, P_PULSE = 1, P_SETTLE = 2, P_PLAY = 3, P_DONE = 4;
  int         phase;
  int         age;
  int         cur;     // hole currently lit, -1 when none
  int         prev;    // last hole placed
  int         sc;
  logic [7:0] lf;
  logic [7:0] lf_now;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function void place(input logic [7:0] l);
    int idx;
    idx = int'(l) % NH;
    if (idx == prev) idx = (idx + 1) % NH;
    prev = idx;
    cur  = idx;
  endfunction

  function automatic logic [NH-1:0] mdl_mole();
    return (cur < 0) ? '0 : (NH'(1) << cur);
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      phase = P_IDLE; lf = 8'hA5; age = 0; cur = -1; prev = 0; sc = 0;
    end else begin
      lf_now = lf;
      lf     = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      case (phase)
        P_IDLE, P_DONE: if (start) begin phase = P_PULSE; sc = 0; cur = -1; end
        P_PULSE:  phase = P_SETTLE;
        P_SETTLE: begin place(lf_now); age = 0; phase = P_PLAY; end
        default: begin
          if (cur >= 0 && hit[cur]) begin
            sc  = min_i(sc + 1, SMAX);
            cur = -1;
          end else if (hit != '0 && PENALTY) begin
            sc = (sc > 0) ? sc - 1 : 0;
          end
          if (finish_60s) begin
            phase = P_DONE;
            cur   = -1;
          end else if (age == MP - 1) begin
            place(lf_now);
            age = 0;
          end else begin
            age++;
          end
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    check("start_60s", start_60s, phase == P_PULSE);
    check("mole", mole, mdl_mole());
    check("score", score, sc);
    check("game_over", game_over, phase == P_DONE);
    check("disp_sel", disp_sel, phase == P_DONE);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_lit(input logic [NH-1:0] want, input bit any, input int budget, input string tag);
    int n = 0;
    while (!(any ? (mdl_mole() != '0) : (mdl_mole() == want)) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check(tag, 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int saved;
    logic [NH-1:0] bit_hit;

    // reset and idle
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    repeat (4) tick();
    check("idle_start_60s", start_60s, 0);

    // start with a stale finish level held through the arming cycles
    finish_60s = 1'b1;
    pulse_start();
    check("arm_pulse", start_60s, 1);
    tick();
    check("arm_pulse_gone", start_60s, 0);
    tick();
    finish_60s = 1'b0;
    check("run_mole_onehot", $countones(mole), 1);
    check("stale_finish_ignored", game_over, 0);
    repeat (35) tick();

    // first hit, repeat hit on the same bit
    wait_lit('0, 1'b1, 20, "wait_first_mole");
    bit_hit = mdl_mole();
    hit = bit_hit; tick(); hit = '0;
    check("first_hit_score", score, 1);
    check("hit_clears_mole", mole, 0);
    hit = bit_hit; tick(); hit = '0;
    check("repeat_hit_score", score, PENALTY ? 0 : 1);

    // all buttons pressed while hole 2 is lit
    wait_lit(4'b0100, 1'b0, 300, "wait_mole_0100");
    saved = sc;
    hit = 4'b1111; tick(); hit = '0;
    check("all_bits_hit", score, saved + 1);

    // hit and finish in the same cycle
    wait_lit('0, 1'b1, 20, "wait_end_mole");
    saved = sc;
    hit = mdl_mole(); finish_60s = 1'b1; tick(); hit = '0;
    check("finish_hit_score", score, saved + 1);
    check("finish_game_over", game_over, 1);
    check("finish_disp_sel", disp_sel, 1);
    check("finish_mole_off", mole, 0);
    tick(); finish_60s = 1'b0;
    tick();
    pulse_start();
    check("restart_score", score, 0);
    check("restart_pulse", start_60s, 1);

    // saturation over 120 moles
    for (int m = 0; m < 120; m++) begin
      wait_lit('0, 1'b1, 15, "wait_sat_mole");
      hit = mdl_mole(); tick(); hit = '0;
    end
    check("score_saturated", score, SMAX);
    wait_lit('0, 1'b1, 15, "wait_sat_extra");
    hit = mdl_mole(); tick(); hit = '0;
    check("score_stays_max", score, SMAX);

    // end game and run random play
    finish_60s = 1'b1; tick(); finish_60s = 1'b0;
    pulse_start();
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 4))
        0: hit = mdl_mole();
        1: hit = NH'($urandom);
        2: hit = mdl_mole() | NH'($urandom);
        default: hit = '0;
      endcase
      start      = ($urandom_range(0, 40) == 0);
      finish_60s = ($urandom_range(0, 150) == 0);
      tick();
      if (phase == P_DONE && $urandom_range(0, 3) == 0) start = 1'b1;
    end
    hit = '0; start = 1'b0; finish_60s = 1'b0;

    // start ignored mid-game
    finish_60s = 1'b1; tick(); finish_60s = 1'b0;
    pulse_start();
    repeat (3) tick();
    wait_lit('0, 1'b1, 15, "wait_mid_mole");
    hit = mdl_mole(); tick(); hit = '0;
    saved = sc;
    pulse_start();
    check("mid_start_no_pulse", start_60s, 0);
    check("mid_start_score", score, saved);

    // asynchronous abort mid-game
    repeat (2) tick();
    #1 Rst = 1'b0;
    #1;
    check("abort_score", score, 0);
    check("abort_mole", mole, 0);
    check("abort_disp_sel", disp_sel, 0);
    repeat (2) tick();
    Rst = 1'b1;
    repeat (3) tick();
    check("post_abort_idle", start_60s | game_over | disp_sel, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
